// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to a keyboard using
// the host-initiated protocol (clock inhibit, start bit, 8 data bits LSB first,
// odd parity, stop bit, device ACK). Lines are open-drain: *_oe=1 pulls low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_XMIT      = 3'd2;
    localparam logic [2:0] S_ACK       = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    data_q;
    logic          parity_q;
    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          fall_q;

    // No acceptance while a done/err pulse is still on the outputs.
    assign tx_ready = (state == S_IDLE) && !done && !err;

    // Two-flop synchronizers plus a registered falling-edge strobe, so the FSM
    // acts on an edge one cycle after it is detected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            clk_prev <= 1'b0;
            dat_s1   <= 1'b0;
            dat_s2   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data_in;
            dat_s2   <= dat_s1;
            fall_q   <= clk_prev & ~clk_s2;
        end
    end

    // Transfer FSM: inhibit, shift frame on device clock edges, check ACK,
    // wait for bus idle; a stalled device clock aborts with err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == S_IDLE) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                if (tx_valid && tx_ready) begin
                    data_q     <= tx_data;
                    parity_q   <= ~^tx_data;
                    cnt        <= '0;
                    ps2_clk_oe <= 1'b1;
                    state      <= S_INHIBIT;
                end
            end else if (state == S_INHIBIT) begin
                if (cnt == INH_LAST) begin
                    // Start bit goes out as the clock is released.
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b1;
                    bit_cnt     <= '0;
                    cnt         <= '0;
                    state       <= S_XMIT;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state == S_XMIT || state == S_ACK || state == S_WAIT_IDLE) begin
                if (fall_q) cnt <= '0;
                else        cnt <= cnt + 1'b1;

                if (!fall_q && cnt == TO_LAST) begin
                    err         <= 1'b1;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= S_IDLE;
                end else if (state == S_XMIT) begin
                    if (fall_q) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt < 4'd8) begin
                            ps2_data_oe <= ~data_q[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            ps2_data_oe <= ~parity_q;
                        end else begin
                            ps2_data_oe <= 1'b0;  // stop bit: release
                            state       <= S_ACK;
                        end
                    end
                end else if (state == S_ACK) begin
                    if (fall_q) begin
                        if (!dat_s2) begin
                            state <= S_WAIT_IDLE;
                        end else begin
                            err         <= 1'b1;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end else begin
                    if (clk_s2 && dat_s2) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
            end else begin
                state       <= S_IDLE;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
            end
        end
    end

endmodule
